// File: rtl/npu_csr_pkg.sv
// Register map, bit positions and CTRL layout for the NPU control/status block.
package npu_csr_pkg;

    localparam logic [7:0] CtrlOff   = 8'h00;
    localparam logic [7:0] StatusOff = 8'h04;
    localparam logic [7:0] SrcOff    = 8'h08;
    localparam logic [7:0] DstOff    = 8'h0C;
    localparam logic [7:0] LenOff    = 8'h10;
    localparam logic [7:0] CyclesOff = 8'h14;

    localparam int CtrlStartBit  = 0;
    localparam int CtrlIrqEnBit  = 1;
    localparam int StatusBusyBit = 0;
    localparam int StatusDoneBit = 1;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        irqEn;
        logic        start;
    } npu_csr_ctrl_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle without write strobes; s is the responder view, m the requester view.
interface axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport s (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport m (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/npu_csr_regs.sv
// AXI-Lite responder for the NPU CSR file: independent AW/W holding registers,
// buffered B response, registered read data, and the job-launch interface.
module npu_csr_regs
    import npu_csr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst_n,
    axil_if.s                 csr,
    output logic              start_o,
    output logic [DATA_W-1:0] src_addr_o,
    output logic [DATA_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] len_o,
    input  logic              busy_i,
    input  logic              done_i,
    output logic              irq_o
);

    logic              awFull_q, awFull_d;
    logic [5:0]        awIdx_q, awIdx_d;
    logic              wFull_q, wFull_d;
    logic [DATA_W-1:0] wData_q, wData_d;
    logic              bValid_q, bValid_d;
    logic              rValid_q, rValid_d;
    logic [DATA_W-1:0] rData_q, rData_d;
    npu_csr_ctrl_t     ctrl_q, ctrl_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [DATA_W-3:0] len_q, len_d;
    logic [DATA_W-1:0] cycles_q, cycles_d;

    logic              awHs, wHs, arHs, commit, startCmd;
    logic [7:0]        wrOff, rdOff;
    npu_csr_ctrl_t     ctrlWr;
    logic [DATA_W-1:0] rdMux;
    logic              unused_addr_bits;

    assign awHs     = csr.awvalid & ~awFull_q;
    assign wHs      = csr.wvalid & ~wFull_q;
    assign arHs     = csr.arvalid & ~rValid_q;
    assign commit   = awFull_q & wFull_q & ~bValid_q;
    assign wrOff    = {awIdx_q, 2'b00};
    assign rdOff    = {csr.araddr[7:2], 2'b00};
    assign ctrlWr   = npu_csr_ctrl_t'(wData_q);
    assign startCmd = commit && (wrOff == CtrlOff) && ctrlWr.start;

    assign unused_addr_bits = ^{csr.awaddr[ADDR_W-1:8], csr.awaddr[1:0],
                                csr.araddr[ADDR_W-1:8], csr.araddr[1:0]};

    assign csr.awready = ~awFull_q;
    assign csr.wready  = ~wFull_q;
    assign csr.bvalid  = bValid_q;
    assign csr.bresp   = 2'b00;
    assign csr.arready = ~rValid_q;
    assign csr.rvalid  = rValid_q;
    assign csr.rdata   = rData_q;
    assign csr.rresp   = 2'b00;

    assign start_o    = start_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign len_o      = {len_q, 2'b00};
    assign irq_o      = done_q & ctrl_q.irqEn;

    // Read decode uses current register state, so a read that races a commit sees the old value.
    always_comb begin
        rdMux = '0;
        case (rdOff)
            CtrlOff: rdMux = ctrl_q;
            StatusOff: begin
                rdMux[StatusBusyBit] = busy_i;
                rdMux[StatusDoneBit] = done_q;
            end
            SrcOff:    rdMux = src_q;
            DstOff:    rdMux = dst_q;
            LenOff:    rdMux = {len_q, 2'b00};
            CyclesOff: rdMux = cycles_q;
            default:   rdMux = '0;
        endcase
    end

    always_comb begin
        awFull_d = awFull_q;
        awIdx_d  = awIdx_q;
        wFull_d  = wFull_q;
        wData_d  = wData_q;
        bValid_d = bValid_q;
        rValid_d = rValid_q;
        rData_d  = rData_q;
        ctrl_d   = ctrl_q;
        done_d   = done_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        cycles_d = cycles_q;
        start_d  = startCmd;

        if (commit) begin
            awFull_d = 1'b0;
            wFull_d  = 1'b0;
            bValid_d = 1'b1;
            case (wrOff)
                CtrlOff:   ctrl_d.irqEn = ctrlWr.irqEn;
                StatusOff: if (wData_q[StatusDoneBit]) done_d = 1'b0;
                SrcOff:    src_d = wData_q;
                DstOff:    dst_d = wData_q;
                LenOff:    len_d = wData_q[DATA_W-1:2];
                default:   ;
            endcase
        end else if (bValid_q && csr.bready) begin
            bValid_d = 1'b0;
        end

        if (awHs) begin
            awFull_d = 1'b1;
            awIdx_d  = csr.awaddr[7:2];
        end
        if (wHs) begin
            wFull_d = 1'b1;
            wData_d = csr.wdata;
        end

        // A DONE pulse overrides a simultaneous write-1-to-clear.
        if (done_i) done_d = 1'b1;

        if (startCmd) begin
            cycles_d = '0;
        end else if (busy_i && (cycles_q != '1)) begin
            cycles_d = cycles_q + {{(DATA_W-1){1'b0}}, 1'b1};
        end

        if (arHs) begin
            rValid_d = 1'b1;
            rData_d  = rdMux;
        end else if (rValid_q && csr.rready) begin
            rValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            awFull_q <= 1'b0;
            awIdx_q  <= '0;
            wFull_q  <= 1'b0;
            wData_q  <= '0;
            bValid_q <= 1'b0;
            rValid_q <= 1'b0;
            rData_q  <= '0;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cycles_q <= '0;
        end else begin
            awFull_q <= awFull_d;
            awIdx_q  <= awIdx_d;
            wFull_q  <= wFull_d;
            wData_q  <= wData_d;
            bValid_q <= bValid_d;
            rValid_q <= rValid_d;
            rData_q  <= rData_d;
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            start_q  <= start_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cycles_q <= cycles_d;
        end
    end

endmodule

// File: tb/tb_npu_csr_regs.sv
// Directed bench for npu_csr_regs: a table of write/read-back vectors plus
// hand-timed sequences for handshake latency, W1C races, backpressure and reset.
module tb_npu_csr_regs;
    import npu_csr_pkg::*;

    localparam logic [31:0] Base = 32'hC000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } vec_t;

    logic        clk;
    logic        srst_n;
    logic        start_o;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [31:0] len_o;
    logic        busy_i;
    logic        done_i;
    logic        irq_o;

    int          testsRun;
    int          testsFailed;
    logic [31:0] rd;
    vec_t        vecs [10];

    axil_if #(.ADDR_W(32), .DATA_W(32)) csrBus ();

    npu_csr_regs #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .csr        (csrBus),
        .start_o    (start_o),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .len_o      (len_o),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out waiting for the DUT handshake", name);
    endtask

    // Presents AW and W together; returns 1 time unit after the edge on which both were accepted.
    task automatic sendWrite(input logic [31:0] addr, input logic [31:0] data);
        bit awDone, wDone, awFire, wFire;
        int n;
        awDone = 1'b0;
        wDone  = 1'b0;
        n      = 0;
        @(posedge clk); #1;
        csrBus.awvalid = 1'b1;
        csrBus.awaddr  = addr;
        csrBus.wvalid  = 1'b1;
        csrBus.wdata   = data;
        while (!(awDone && wDone) && n < 40) begin
            @(negedge clk);
            awFire = csrBus.awvalid && csrBus.awready;
            wFire  = csrBus.wvalid && csrBus.wready;
            @(posedge clk); #1;
            if (awFire) begin
                csrBus.awvalid = 1'b0;
                awDone = 1'b1;
            end
            if (wFire) begin
                csrBus.wvalid = 1'b0;
                wDone = 1'b1;
            end
            n++;
        end
        if (!(awDone && wDone)) begin
            timeoutFail("sendWrite");
            csrBus.awvalid = 1'b0;
            csrBus.wvalid  = 1'b0;
        end
    endtask

    task automatic finishWrite();
        int n;
        n = 0;
        csrBus.bready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!csrBus.bvalid && n < 40);
        if (!csrBus.bvalid) timeoutFail("bvalid");
        @(posedge clk); #1;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        bit arFire;
        int n;
        n = 0;
        @(posedge clk); #1;
        csrBus.arvalid = 1'b1;
        csrBus.araddr  = addr;
        csrBus.rready  = 1'b1;
        do begin
            @(negedge clk);
            arFire = csrBus.arvalid && csrBus.arready;
            @(posedge clk); #1;
            n++;
        end while (!arFire && n < 40);
        csrBus.arvalid = 1'b0;
        if (!arFire) timeoutFail("readReg arready");
        @(negedge clk);
        checkOutput("rvalid one cycle after AR", csrBus.rvalid, 1);
        data = csrBus.rdata;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int idx);
        writeReg(vecs[idx].addr, vecs[idx].wdata);
        readReg(vecs[idx].addr, rd);
        checkOutput($sformatf("vec%0d readback @0x%08h", idx, vecs[idx].addr), rd, vecs[idx].expRead);
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        sendWrite(addr, data);
        finishWrite();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        vecs[0] = '{Base + 32'h08, 32'h8000_0100, 32'h8000_0100};
        vecs[1] = '{Base + 32'h0C, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{Base + 32'h10, 32'h0000_0103, 32'h0000_0100};
        vecs[3] = '{Base + 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[4] = '{Base + 32'h40, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5] = '{Base + 32'h00, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[6] = '{Base + 32'h00, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{Base + 32'h14, 32'h0000_0055, 32'h0000_0000};
        vecs[8] = '{Base + 32'h08, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[9] = '{Base + 32'h04, 32'h0000_0001, 32'h0000_0000};

        srst_n         = 1'b0;
        busy_i         = 1'b0;
        done_i         = 1'b0;
        csrBus.awvalid = 1'b0;
        csrBus.awaddr  = '0;
        csrBus.wvalid  = 1'b0;
        csrBus.wdata   = '0;
        csrBus.bready  = 1'b1;
        csrBus.arvalid = 1'b0;
        csrBus.araddr  = '0;
        csrBus.rready  = 1'b1;

        // Reset state
        #2;
        checkOutput("reset bvalid", csrBus.bvalid, 0);
        checkOutput("reset rvalid", csrBus.rvalid, 0);
        checkOutput("reset rdata", csrBus.rdata, 0);
        checkOutput("reset start_o", start_o, 0);
        checkOutput("reset irq_o", irq_o, 0);
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset awready", csrBus.awready, 1);
        checkOutput("post-reset wready", csrBus.wready, 1);
        checkOutput("post-reset arready", csrBus.arready, 1);

        // SRC write with AW and W together: bvalid two cycles after the handshake
        sendWrite(Base + 32'h08, 32'h8000_0100);
        @(negedge clk);
        checkOutput("t1 bvalid in commit cycle", csrBus.bvalid, 0);
        checkOutput("t1 src_addr_o before update", src_addr_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1 bvalid handshake+2", csrBus.bvalid, 1);
        checkOutput("t1 src_addr_o after commit", src_addr_o, 32'h8000_0100);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1 bvalid after B handshake", csrBus.bvalid, 0);
        readReg(Base + 32'h08, rd);
        checkOutput("t1 read SRC", rd, 32'h8000_0100);

        // W three cycles ahead of AW for LEN
        @(posedge clk); #1;
        csrBus.wvalid = 1'b1;
        csrBus.wdata  = 32'h0000_0103;
        @(posedge clk); #1;
        csrBus.wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t2 wready held low %0d", i), csrBus.wready, 0);
            @(posedge clk); #1;
        end
        csrBus.awvalid = 1'b1;
        csrBus.awaddr  = Base + 32'h10;
        @(posedge clk); #1;
        csrBus.awvalid = 1'b0;
        @(negedge clk);
        checkOutput("t2 wready in commit cycle", csrBus.wready, 0);
        checkOutput("t2 bvalid in commit cycle", csrBus.bvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t2 bvalid after commit", csrBus.bvalid, 1);
        checkOutput("t2 wready after commit", csrBus.wready, 1);
        checkOutput("t2 len_o", len_o, 32'h0000_0100);
        @(posedge clk); #1;
        readReg(Base + 32'h10, rd);
        checkOutput("t2 read LEN", rd, 32'h0000_0100);

        for (int i = 0; i < 10; i++) applyStimulus(i);
        @(negedge clk);
        checkOutput("table src_addr_o", src_addr_o, 32'hA5A5_5A5A);
        checkOutput("table dst_addr_o", dst_addr_o, 32'h1234_5678);
        checkOutput("table len_o", len_o, 32'hFFFF_FFFC);

        // Read handshake in the commit cycle returns the pre-write value
        sendWrite(Base + 32'h08, 32'hCAFE_0001);
        csrBus.arvalid = 1'b1;
        csrBus.araddr  = Base + 32'h08;
        @(posedge clk); #1;
        csrBus.arvalid = 1'b0;
        @(negedge clk);
        checkOutput("race rvalid", csrBus.rvalid, 1);
        checkOutput("race rdata old value", csrBus.rdata, 32'hA5A5_5A5A);
        checkOutput("race bvalid", csrBus.bvalid, 1);
        @(posedge clk); #1;
        readReg(Base + 32'h08, rd);
        checkOutput("race read new value", rd, 32'hCAFE_0001);

        // START + IRQ_EN, then a 10-cycle busy window and a DONE pulse
        sendWrite(Base + 32'h00, 32'h0000_0003);
        @(negedge clk);
        checkOutput("t3 start_o in commit cycle", start_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3 start_o pulse", start_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3 start_o one cycle", start_o, 0);
        @(posedge clk); #1;
        busy_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 busy_i = 1'b0;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        @(negedge clk);
        checkOutput("t3 irq_o", irq_o, 1);
        readReg(Base + 32'h14, rd);
        checkOutput("t3 CYCLES", rd, 32'd10);
        readReg(Base + 32'h04, rd);
        checkOutput("t3 STATUS", rd, 32'h0000_0002);

        // START while busy, with busy high in the commit cycle: clear beats increment
        busy_i = 1'b1;
        sendWrite(Base + 32'h00, 32'h0000_0003);
        @(posedge clk); #1;
        busy_i = 1'b0;
        @(negedge clk);
        checkOutput("start while busy pulse", start_o, 1);
        readReg(Base + 32'h14, rd);
        checkOutput("CYCLES cleared on START", rd, 32'd0);

        // W1C of DONE racing a done_i pulse: set wins
        sendWrite(Base + 32'h04, 32'h0000_0002);
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        readReg(Base + 32'h04, rd);
        checkOutput("t4 DONE kept by race", rd, 32'h0000_0002);
        checkOutput("t4 irq_o kept", irq_o, 1);
        writeReg(Base + 32'h04, 32'h0000_0002);
        readReg(Base + 32'h04, rd);
        checkOutput("t4 DONE cleared", rd, 32'h0000_0000);
        @(negedge clk);
        checkOutput("t4 irq_o cleared", irq_o, 0);

        // B backpressure: second write waits for the first B handshake
        csrBus.bready = 1'b0;
        sendWrite(Base + 32'h08, 32'h1111_1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        sendWrite(Base + 32'h0C, 32'h2222_2222);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5 awready held %0d", i), csrBus.awready, 0);
            checkOutput($sformatf("t5 wready held %0d", i), csrBus.wready, 0);
            checkOutput($sformatf("t5 bvalid held %0d", i), csrBus.bvalid, 1);
            checkOutput($sformatf("t5 dst not yet written %0d", i), dst_addr_o, 32'h1234_5678);
            @(posedge clk); #1;
        end
        checkOutput("t5 first write landed", src_addr_o, 32'h1111_1111);
        csrBus.bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5 bvalid after first B", csrBus.bvalid, 0);
        checkOutput("t5 dst in second commit cycle", dst_addr_o, 32'h1234_5678);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5 second bvalid", csrBus.bvalid, 1);
        checkOutput("t5 dst after second commit", dst_addr_o, 32'h2222_2222);
        checkOutput("t5 awready released", csrBus.awready, 1);
        @(posedge clk); #1;
        readReg(Base + 32'h08, rd);
        checkOutput("t5 read SRC", rd, 32'h1111_1111);

        // Unmapped read, then reset while rvalid is pending
        csrBus.rready  = 1'b0;
        csrBus.arvalid = 1'b1;
        csrBus.araddr  = Base + 32'h40;
        @(posedge clk); #1;
        csrBus.arvalid = 1'b0;
        @(negedge clk);
        checkOutput("t6 rvalid", csrBus.rvalid, 1);
        checkOutput("t6 rdata unmapped", csrBus.rdata, 32'h0);
        checkOutput("t6 rresp", {30'b0, csrBus.rresp}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6 rvalid held without rready", csrBus.rvalid, 1);
        #1 srst_n = 1'b0;
        #1;
        checkOutput("t6 rvalid dropped by reset", csrBus.rvalid, 0);
        checkOutput("t6 src_addr_o reset", src_addr_o, 32'h0);
        checkOutput("t6 dst_addr_o reset", dst_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 srst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t6 no R after reset %0d", i), csrBus.rvalid, 0);
            checkOutput($sformatf("t6 no B after reset %0d", i), csrBus.bvalid, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            readReg(Base + 32'(i * 4), rd);
            checkOutput($sformatf("t6 reg 0x%02h after reset", i * 4), rd, 32'h0);
        end
        checkOutput("t6 irq_o after reset", irq_o, 0);
        checkOutput("t6 len_o after reset", len_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/npu_csr_regs.md
# npu_csr_regs

AXI-Lite responder that terminates the `npu_csr` port driven by the hosted interconnect's MMIO path (the host window at 0xC000_0000). It decodes host register accesses into the NPU control/status register file and drives a job-launch interface into the NPU core. AW and W are accepted independently, writes complete with a buffered B response, and reads return registered data. Both response channels are always OKAY.

## Interface
Parameters:
- `ADDR_W`, 32, AXI-Lite address width; only bits [7:2] are decoded.
- `DATA_W`, 32, register/data width; fixed at 32.

Ports:
- `clk`  in  1  single clock.
- `srst_n`  in  1  reset; asynchronous assert, active-low.
- `csr`  axil_if.s  -  AXI-Lite responder: aw*, w*, b*, ar*, r*. There is no wstrb; full-word writes only. `bresp`/`rresp` are driven 0.
- `start_o`  out  1  one-cycle job-launch pulse.
- `src_addr_o`  out  32  job source address.
- `dst_addr_o`  out  32  job destination address.
- `len_o`  out  32  job length in bytes; bits [1:0] are always 0.
- `busy_i`  in  1  NPU busy level.
- `done_i`  in  1  one-cycle job-complete pulse.
- `irq_o`  out  1  level interrupt, equal to `STATUS.DONE & CTRL.IRQ_EN`.

## Operation
Register map (offset = addr[7:2]×4):
- 0x00 CTRL: bit0 START (write-1 pulses `start_o`; reads 0), bit1 IRQ_EN (rw).
- 0x04 STATUS: bit0 BUSY (ro, mirrors `busy_i`), bit1 DONE (sticky; write-1-to-clear).
- 0x08 SRC_ADDR: rw.
- 0x0C DST_ADDR: rw.
- 0x10 LEN: rw; bits [1:0] read 0 and ignore writes.
- 0x14 CYCLES: ro. Counts cycles with `busy_i`=1. Saturates at 0xFFFF_FFFF. Cleared to 0 on START.
- Any other offset: reads 0, writes ignored, response OKAY.

Write path:
- One-entry AW holding register and one-entry W holding register, each with a full flag.
- `awready` = !aw_full; `wready` = !w_full.
- Commit happens in the cycle where aw_full & w_full & !bvalid. That cycle updates the register, clears both full flags and sets `bvalid`.
- `bvalid` stays high until `bready`; only one write can be outstanding.

Read path:
- `arready` = !rvalid.
- On an AR handshake, `rdata` is registered from the decoded register and `rvalid` is set.
- `rvalid` stays high, with `rdata` stable, until `rready`.

## Timing
- Reset values: all registers 0; `bvalid`, `rvalid`, `rdata`, `start_o`, `irq_o` = 0. `awready`, `wready`, `arready` = 1 from the first cycle after reset is released.
- Write latency: with AW and W in the same cycle N, commit at N+1 and `bvalid` high at N+2. With AW at N and W at M, commit at max(N,M)+1.
- Register outputs (`src_addr_o` etc.) update in the cycle after commit. `start_o` is high for exactly the cycle after a commit with START=1.
- Read latency: AR handshake at N gives `rvalid` at N+1. Back-to-back reads with `rready` held at 1 sustain one read per 2 cycles.
- Simultaneous read and write of the same register: a read handshake in the same cycle as a write commit returns the pre-write value.
- `done_i` and a W1C of DONE in the same cycle: set wins, DONE=1.
- START while `busy_i`=1: the pulse is still issued; the NPU core ignores it.
- `busy_i` rising in the same cycle as START: CYCLES clears to 0 (clear wins over increment).
- Reset asserted mid-transaction: all state is dropped immediately and no B/R response is issued afterwards. The upstream bridge is reset by the same `srst_n`.

## Structure
- Shared package `npu_csr_pkg`:
  - register offset localparams (CtrlOff, StatusOff, SrcOff, DstOff, LenOff, CyclesOff);
  - CTRL/STATUS bit-position constants;
  - packed `npu_csr_ctrl_t` struct.
- No sub-module; the AW/W holding registers are small enough to inline.

## Test plan
- Write SRC_ADDR=0x8000_0100 with AW and W in the same cycle, then read it back -> `bvalid` 2 cycles after handshake; read returns 0x8000_0100 with `rvalid` 1 cycle after AR.
- W issued 3 cycles before AW for LEN=0x0000_0103 -> `wready` low until commit; read LEN returns 0x0000_0100.
- Write CTRL=0x3, then hold `busy_i`=1 for 10 cycles and pulse `done_i` -> `start_o` high 1 cycle; CYCLES reads 10; STATUS reads 0x2; `irq_o`=1.
- Write STATUS=0x2 in the same cycle as `done_i` pulses -> DONE stays 1. A later W1C with no `done_i` -> DONE=0 and `irq_o`=0.
- Hold `bready`=0 for 5 cycles after a write, then issue a second AW+W -> the second write is not committed until the first B handshake; `awready`/`wready` drop while held.
- Read offset 0x40, and reassert `srst_n`=0 while `rvalid` is high -> data 0 with `rresp`=0; after reset, `rvalid`=0 and all registers read 0.
